line_read_buffer: RTL and testbench



---
 rtl/lc3b_types.sv | 19 +
 rtl/word_extract.sv | 21 ++
 rtl/line_read_buffer.sv | 119 +++++++++++
 tb/tb_line_read_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types.
//   lc3b_word         16-bit CPU data/address word
//   lc3b_pmem_line    128-bit physical memory line (8 words)
//   lc3b_cache_offset word select within a line (address bits [3:1])
//   lc3b_line_tag     line tag (address bits [15:4])
//   lc3b_lrb_state    line_read_buffer controller state
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [2:0]   lc3b_cache_offset;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic {
    LRB_IDLE  = 1'b0,
    LRB_FETCH = 1'b1
  } lc3b_lrb_state;

endpackage

// File: rtl/word_extract.sv
// Combinational word selector: returns word[offset] of a 128-bit line.
//   line   in  lc3b_pmem_line     source line
//   offset in  lc3b_cache_offset  word index (address bits [3:1])
//   word   out lc3b_word          selected 16-bit word
module word_extract
  import lc3b_types::*;
(
  input  lc3b_pmem_line    line,
  input  lc3b_cache_offset offset,
  output lc3b_word         word
);

  lc3b_word words [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign words[gi] = line[16*gi +: 16];
  end

  assign word = words[offset];

endmodule

// File: rtl/line_read_buffer.sv
// Single-line read buffer between the CPU data-read port and lower memory.
// Holds one line plus tag; hits return in one cycle, misses fetch the whole
// line from below and answer the CPU on the fill edge. Snooped writes to the
// buffered (or in-flight) line invalidate it.
//   clk, reset_n                 clock, async active-low reset
//   mem_address/mem_read         CPU read request (held until mem_resp)
//   mem_rdata/mem_resp           returned word, one-cycle acknowledge
//   lower_address/lower_read     line fetch request (held until lower_resp)
//   lower_rdata/lower_resp       fetched line, one-cycle acknowledge
//   snoop_write/snoop_address    write committing to memory this cycle
module line_read_buffer
  import lc3b_types::*;
#(
  parameter bit HIT_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output lc3b_word      lower_address,
  output logic          lower_read,
  input  lc3b_pmem_line lower_rdata,
  input  logic          lower_resp,
  input  logic          snoop_write,
  input  lc3b_word      snoop_address
);

  lc3b_lrb_state    state_reg;
  lc3b_pmem_line    line_reg;
  lc3b_line_tag     tag_reg;
  lc3b_cache_offset offset_reg;
  logic             valid_reg;
  logic             poison_reg;

  lc3b_line_tag     req_tag;
  lc3b_cache_offset req_offset;
  lc3b_word         hit_word;
  lc3b_word         fill_word;
  logic             snoop_match;
  logic             hit;

  // Byte-lane and sub-line snoop bits carry no information for a line buffer.
  logic unused_bits;
  assign unused_bits = ^{mem_address[0], snoop_address[3:0]};

  assign req_tag    = mem_address[15:4];
  assign req_offset = mem_address[3:1];

  // In FETCH tag_reg already holds the in-flight tag, so the same compare
  // serves both invalidation (IDLE) and poisoning (FETCH).
  assign snoop_match = snoop_write & (snoop_address[15:4] == tag_reg);
  assign hit = HIT_ENABLE & valid_reg & (tag_reg == req_tag) & ~snoop_match;

  word_extract u_hit_extract (
    .line   (line_reg),
    .offset (req_offset),
    .word   (hit_word)
  );

  word_extract u_fill_extract (
    .line   (lower_rdata),
    .offset (offset_reg),
    .word   (fill_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= LRB_IDLE;
      line_reg      <= '0;
      tag_reg       <= '0;
      offset_reg    <= '0;
      valid_reg     <= 1'b0;
      poison_reg    <= 1'b0;
      mem_resp      <= 1'b0;
      mem_rdata     <= '0;
      lower_read    <= 1'b0;
      lower_address <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state_reg)
        LRB_IDLE: begin
          if (snoop_match) valid_reg <= 1'b0;
          // A request still high during its response cycle is the same
          // request; skipping it prevents a double acknowledge.
          if (mem_read && !mem_resp) begin
            if (hit) begin
              mem_resp  <= 1'b1;
              mem_rdata <= hit_word;
            end else begin
              state_reg     <= LRB_FETCH;
              lower_read    <= 1'b1;
              lower_address <= {req_tag, 4'b0000};
              tag_reg       <= req_tag;
              offset_reg    <= req_offset;
              valid_reg     <= 1'b0;
              poison_reg    <= 1'b0;
            end
          end
        end
        LRB_FETCH: begin
          if (snoop_match) poison_reg <= 1'b1;
          if (lower_resp) begin
            line_reg   <= lower_rdata;
            // The CPU still gets its word; only retention is suppressed.
            valid_reg  <= ~poison_reg & ~snoop_match;
            mem_resp   <= 1'b1;
            mem_rdata  <= fill_word;
            lower_read <= 1'b0;
            state_reg  <= LRB_IDLE;
          end
        end
        default: state_reg <= LRB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_read_buffer.sv
module tb_line_read_buffer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  lower_address;
  logic         lower_read;
  logic [127:0] lower_rdata = '0;
  logic         lower_resp = 1'b0;
  logic         snoop_write = 1'b0;
  logic [15:0]  snoop_address = '0;

  // Second instance with hits disabled.
  logic [15:0]  b_mem_address = '0;
  logic         b_mem_read = 1'b0;
  logic [15:0]  b_mem_rdata;
  logic         b_mem_resp;
  logic [15:0]  b_lower_address;
  logic         b_lower_read;
  logic [127:0] b_lower_rdata = '0;
  logic         b_lower_resp = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  line_read_buffer #(.HIT_ENABLE(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp),
    .lower_address (lower_address),
    .lower_read    (lower_read),
    .lower_rdata   (lower_rdata),
    .lower_resp    (lower_resp),
    .snoop_write   (snoop_write),
    .snoop_address (snoop_address)
  );

  line_read_buffer #(.HIT_ENABLE(1'b0)) dut_nohit (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_address   (b_mem_address),
    .mem_read      (b_mem_read),
    .mem_rdata     (b_mem_rdata),
    .mem_resp      (b_mem_resp),
    .lower_address (b_lower_address),
    .lower_read    (b_lower_read),
    .lower_rdata   (b_lower_rdata),
    .lower_resp    (b_lower_resp),
    .snoop_write   (1'b0),
    .snoop_address (16'h0000)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Lower-memory model: line 0x123 holds words 0000..7777, others are
  // derived from the tag so every word is distinct.
  function automatic logic [127:0] line_of(input logic [11:0] tag);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) begin
      if (tag == 12'h123) l[16*i +: 16] = 16'(i * 16'h1111);
      else                l[16*i +: 16] = {tag, 1'b0, 3'(i)};
    end
    return l;
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] addr);
    logic [127:0] l;
    l = line_of(addr[15:4]);
    return l[16*addr[3:1] +: 16];
  endfunction

  // snoop_mode: 0 none, 1 snoop with the request, 2 snoop when fetch starts
  task automatic do_read(input logic [15:0] addr, input bit exp_fetch,
                         input int snoop_mode, input logic [15:0] s_addr,
                         input string name);
    logic [15:0] exp_w;
    logic [15:0] sb_w;
    bit fetched, sent, got;
    int cnt, sent_cyc, got_cyc;
    exp_w = word_of(addr);
    sb_q.push_back(exp_w);
    mem_address = addr;
    mem_read = 1'b1;
    if (snoop_mode == 1) begin
      snoop_write = 1'b1;
      snoop_address = s_addr;
    end
    fetched = 0; sent = 0; got = 0; cnt = 0; sent_cyc = -1; got_cyc = -1;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      snoop_write = 1'b0;
      if (lower_resp) lower_resp = 1'b0;
      if (mem_resp) begin
        got = 1;
        got_cyc = cyc;
        sb_w = sb_q.pop_front();
        chk({name, "_data"}, 32'(mem_rdata), 32'(sb_w));
      end else if (lower_read) begin
        if (!fetched) begin
          fetched = 1;
          cnt = 3;
          chk({name, "_laddr"}, 32'(lower_address), 32'({addr[15:4], 4'h0}));
          if (snoop_mode == 2) begin
            snoop_write = 1'b1;
            snoop_address = s_addr;
          end
        end
        if (!sent) begin
          if (cnt <= 1) begin
            lower_resp = 1'b1;
            lower_rdata = line_of(addr[15:4]);
            sent = 1;
            sent_cyc = cyc;
          end else begin
            cnt--;
          end
        end
      end
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else if (exp_fetch) begin
      chk({name, "_lat"}, 32'(got_cyc), 32'(sent_cyc + 1));
    end else begin
      chk({name, "_lat"}, 32'(got_cyc), 32'd0);
    end
    chk({name, "_fetch"}, 32'(fetched), 32'(exp_fetch));
    // Request still held through the response cycle: no second acknowledge.
    @(negedge clk);
    chk({name, "_noresp2"}, 32'(mem_resp), 32'd0);
    chk({name, "_hold"}, 32'(mem_rdata), 32'(exp_w));
    mem_read = 1'b0;
  endtask

  task automatic read_b(input logic [15:0] addr, input string name);
    bit seen, got;
    logic [15:0] sb_w;
    sb_q.push_back(word_of(addr));
    b_mem_address = addr;
    b_mem_read = 1'b1;
    seen = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (b_lower_resp) b_lower_resp = 1'b0;
      if (b_mem_resp) begin
        got = 1;
        sb_w = sb_q.pop_front();
        chk({name, "_data"}, 32'(b_mem_rdata), 32'(sb_w));
      end else if (b_lower_read && !seen) begin
        seen = 1;
        chk({name, "_laddr"}, 32'(b_lower_address), 32'({addr[15:4], 4'h0}));
        b_lower_resp = 1'b1;
        b_lower_rdata = line_of(addr[15:4]);
      end
    end
    if (!got) void'(sb_q.pop_front());
    chk({name, "_got"}, 32'(got), 32'd1);
    chk({name, "_fetch"}, 32'(seen), 32'd1);
    @(negedge clk);
    b_mem_read = 1'b0;
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_lower_read", 32'(lower_read), 32'd0);
    chk("rst_lower_addr", 32'(lower_address), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_read(16'h1236, 1, 0, 16'h0, "cold_miss");
    do_read(16'h123E, 0, 0, 16'h0, "hit_fill");
    do_read(16'h4000, 1, 0, 16'h0, "new_line");
    do_read(16'h1230, 1, 0, 16'h0, "old_line_miss");
    do_read(16'h4002, 1, 0, 16'h0, "refill_400");
    do_read(16'h4004, 0, 0, 16'h0, "hit_400");

    // Snoop to a different line is ignored.
    snoop_write = 1'b1; snoop_address = 16'h1230;
    @(negedge clk);
    snoop_write = 1'b0;
    do_read(16'h4002, 0, 0, 16'h0, "snoop_other_hit");

    // Snoop to the buffered line while idle invalidates it.
    snoop_write = 1'b1; snoop_address = 16'h4008;
    @(negedge clk);
    snoop_write = 1'b0;
    do_read(16'h4002, 1, 0, 16'h0, "snoop_idle_miss");

    // Snoop in the same cycle as a would-be hit.
    do_read(16'h4002, 1, 1, 16'h4004, "snoop_same_cyc");
    do_read(16'h4006, 0, 0, 16'h0, "after_snoop_hit");

    // Poison during fetch: word returned, line not kept.
    do_read(16'h5000, 1, 2, 16'h500A, "poison_fill");
    do_read(16'h5000, 1, 0, 16'h0, "poison_refetch");
    do_read(16'h5002, 0, 0, 16'h0, "poison_then_hit");

    // Reset two cycles into a fetch.
    mem_address = 16'h6000;
    mem_read = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (lower_read) seen = 1;
    end
    chk("rst_fetch_start", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_lower_read", 32'(lower_read), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    lower_resp = 1'b1;
    lower_rdata = line_of(12'h600);
    @(negedge clk);
    lower_resp = 1'b0;
    chk("late_resp_ignored", 32'(mem_resp), 32'd0);
    @(negedge clk);
    chk("late_resp_no_fetch", 32'(lower_read), 32'd0);
    do_read(16'h5002, 1, 0, 16'h0, "post_reset_miss");

    // Hit path disabled: every read fetches.
    read_b(16'h1232, "nohit_first");
    read_b(16'h1234, "nohit_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
